raw_hazard_scoreboard: RTL
==========================

// Module: raw_hazard_scoreboard
// PURPOSE
//  Parametrised successor to the combinational RAW check: a per-register scoreboard that tracks in-flight
//  writes between issue and writeback. Sits at the issue stage and holds an instruction whose source
//  registers have pending writes. Supports multiple outstanding writes per register, optional writeback
//  bypass, pipeline flush and a saturating stall-cycle counter for performance monitoring.
// PARAMETERS
//  NUM_REGS      32  architectural registers tracked
//  REG_ADDR_W    5   register index width, ceil(log2(NUM_REGS))
//  MAX_INFLIGHT  3   max outstanding writes per register; CNT_W = clog2(MAX_INFLIGHT+1)
//  BYPASS_WB     1   1: writeback in the same cycle clears a dependence on its last pending write
//  ZERO_REG      1   1: register 0 is hardwired, never pending, never counted
//  STALL_CNT_W   32  width of stall_cycles
// PORTS
//  clk             in   1           clock, rising edge
//  rst             in   1           reset, asynchronous, active-high
//  issue_valid     in   1           decoded instruction presented for issue
//  issue_rs1       in   REG_ADDR_W  source 1 index
//  issue_rs1_used  in   1           instruction reads rs1
//  issue_rs2       in   REG_ADDR_W  source 2 index
//  issue_rs2_used  in   1           instruction reads rs2
//  issue_rd        in   REG_ADDR_W  destination index
//  issue_rd_wen    in   1           instruction writes rd
//  issue_ready     out  1           instruction may issue this cycle
//  has_RAW_dependence out 1         a used source has an unresolved pending write
//  wb_valid        in   1           one register write retires this cycle
//  wb_rd           in   REG_ADDR_W  retiring destination index
//  flush           in   1           discard all in-flight writes
//  any_pending     out  1           some register count is non-zero
//  wb_underflow    out  1           sticky: writeback to a register with count 0
//  stall_cycles    out  STALL_CNT_W cycles with issue_valid && !issue_ready
// BEHAVIOUR
//  - Reset (async): all cnt[r]=0, wb_underflow=0, stall_cycles=0; issue_ready follows combinationally.
//  - pend(s) = cnt[s]!=0 && !(ZERO_REG && s==0) && !(BYPASS_WB && wb_valid && wb_rd==s && cnt[s]==1).
//  - has_RAW_dependence = issue_valid && ((rs1_used && pend(rs1)) || (rs2_used && pend(rs2))); combinational.
//  - issue_ready = !has_RAW_dependence && !flush && !(rd_wen && cnt[rd]==MAX_INFLIGHT && rd!=0-if-ZERO_REG).
//    No issue_valid dependence on ready (no combinational loop); fire = issue_valid && issue_ready.
//  - Per register r, next cycle: inc = fire && rd_wen && rd==r (suppressed for r==0 when ZERO_REG);
//    dec = wb_valid && wb_rd==r && cnt[r]!=0; cnt += inc - dec. inc and dec together: unchanged.
//    Saturation at MAX_INFLIGHT is impossible, because issue_ready already blocks it.
//  - wb_valid to r with cnt[r]==0 (ZERO_REG r==0 excluded): no count change, wb_underflow<=1 until reset/flush.
//  - flush: next cycle all cnt=0 and wb_underflow=0; issue and wb in the flush cycle are ignored; stall_cycles
//    is not cleared but does not count the flush cycle.
//  - stall_cycles: +1 per cycle issue_valid && !issue_ready && !flush; holds at all-ones.
//  - any_pending = OR of (cnt[r]!=0); registered counts only, zero latency.
//  - Indices >= NUM_REGS: treated as never pending and never counted.
// STRUCTURE
//  - Package tinycpu_hazard_pkg: REG_ADDR_W, NUM_REGS defaults, reg_idx_t typedef, issue_req_t struct
//    (rs1, rs1_used, rs2, rs2_used, rd, rd_wen) shared with the decoder.
//  - Sub-module raw_pending_counter: one CNT_W up/down counter with inc, dec, clr, at_max, nonzero, underflow;
//    generate-instantiated NUM_REGS times. Top level holds comparators, bypass, ready and stall logic.
// TESTING
//  1 Issue rd=5 wen; next cycle issue rs1=5 used -> issue_ready=0, has_RAW_dependence=1 until wb_rd=5.
//  2 BYPASS_WB=1, cnt[7]=1; same cycle wb_rd=7 and issue rs2=7 -> issue_ready=1, cnt[7] ends 0 (or 1 if rd=7).
//  3 MAX_INFLIGHT=3: issue rd=3 three times with no wb -> 4th writer of x3 stalls, stall_cycles +1 per cycle.
//  4 ZERO_REG=1: issue rd=0 wen then rs1=0 used -> never stalls, any_pending stays 0; wb_rd=0 sets no underflow.
//  5 cnt[2]=2,cnt[9]=1, flush -> next cycle all counts 0, any_pending=0; the issue in the flush cycle is dropped.
//  6 wb_rd=4 with cnt[4]=0 -> wb_underflow=1 sticky; assert rst mid-stall -> all outputs to reset values at once.

Source files
------------

// File: rtl/raw_hazard_scoreboard_pkg.sv
// Shared hazard-tracking types and default sizes used by the decoder and issue-stage scoreboard.
// Pure declarations: no latency, no flow control.
package tinycpu_hazard_pkg;

    localparam int NUM_REGS     = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int MAX_INFLIGHT = 3;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t rs1;
        logic     rs1_used;
        reg_idx_t rs2;
        logic     rs2_used;
        reg_idx_t rd;
        logic     rd_wen;
    } issue_req_t;

endpackage

// File: rtl/raw_hazard_scoreboard_if.sv
// Issue/writeback/flush bundle between the issue stage and the RAW scoreboard.
// Issue uses valid/ready; writeback and flush are unconditional single-cycle events.
interface raw_hazard_scoreboard_if #(
    parameter int REG_ADDR_W  = tinycpu_hazard_pkg::REG_ADDR_W,
    parameter int STALL_CNT_W = 32
);
    logic                   issue_valid;
    logic [REG_ADDR_W-1:0]  issue_rs1;
    logic                   issue_rs1_used;
    logic [REG_ADDR_W-1:0]  issue_rs2;
    logic                   issue_rs2_used;
    logic [REG_ADDR_W-1:0]  issue_rd;
    logic                   issue_rd_wen;
    logic                   issue_ready;
    logic                   has_RAW_dependence;
    logic                   wb_valid;
    logic [REG_ADDR_W-1:0]  wb_rd;
    logic                   flush;
    logic                   any_pending;
    logic                   wb_underflow;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
               issue_rd, issue_rd_wen, wb_valid, wb_rd, flush,
        input  issue_ready, has_RAW_dependence, any_pending, wb_underflow, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
               issue_rd, issue_rd_wen, wb_valid, wb_rd, flush,
        output issue_ready, has_RAW_dependence, any_pending, wb_underflow, stall_cycles
    );

endinterface

// File: rtl/raw_hazard_scoreboard_counter.sv
// Per-register count of in-flight writes; updates one cycle after inc/dec, clr wins.
// No backpressure: the owner must never raise inc at MAX (at_max tells it when to hold off).
module raw_pending_counter #(
    parameter int CNT_W = 2,
    parameter int MAX   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec_req,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max,
    output logic             nonzero,
    output logic             underflow
);
    logic dec;

    assign nonzero   = (cnt != '0);
    assign dec       = dec_req && nonzero;
    assign underflow = dec_req && !nonzero;
    assign at_max    = (cnt == CNT_W'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/raw_hazard_scoreboard.sv
// Issue-stage RAW scoreboard: ready/dependence are combinational, counts update next cycle.
// Holds issue while a used source is pending or rd already has MAX_INFLIGHT writes outstanding.
module raw_hazard_scoreboard #(
    parameter int NUM_REGS     = tinycpu_hazard_pkg::NUM_REGS,
    parameter int REG_ADDR_W   = tinycpu_hazard_pkg::REG_ADDR_W,
    parameter int MAX_INFLIGHT = tinycpu_hazard_pkg::MAX_INFLIGHT,
    parameter bit BYPASS_WB    = 1'b1,
    parameter bit ZERO_REG     = 1'b1,
    parameter int STALL_CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    raw_hazard_scoreboard_if.slave bus
);
    import tinycpu_hazard_pkg::*;

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [CNT_W-1:0]       cnt [NUM_REGS];
    logic [NUM_REGS-1:0]    at_max, nonzero, underflow, inc, dec_req;
    logic [CNT_W-1:0]       cnt_rs1, cnt_rs2;
    logic                   rd_at_max;
    logic                   rs1_pend, rs2_pend, rd_full, raw, ready, fire;
    logic                   underflow_q;
    logic [STALL_CNT_W-1:0] stall_q;

    // A writeback retiring the last pending write of s resolves the hazard in the same cycle.
    function automatic logic pend(input logic [REG_ADDR_W-1:0] s, input logic [CNT_W-1:0] c,
                                  input logic wb_v, input logic [REG_ADDR_W-1:0] wb_r);
        return (c != '0) && !(ZERO_REG && s == '0) &&
               !(BYPASS_WB && wb_v && wb_r == s && c == CNT_W'(1));
    endfunction

    // Indices beyond NUM_REGS match no entry and so read as idle.
    always_comb begin
        cnt_rs1   = '0;
        cnt_rs2   = '0;
        rd_at_max = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (bus.issue_rs1 == REG_ADDR_W'(r)) cnt_rs1 = cnt[r];
            if (bus.issue_rs2 == REG_ADDR_W'(r)) cnt_rs2 = cnt[r];
            if (bus.issue_rd == REG_ADDR_W'(r))  rd_at_max = at_max[r];
        end
    end

    assign rs1_pend = pend(bus.issue_rs1, cnt_rs1, bus.wb_valid, bus.wb_rd);
    assign rs2_pend = pend(bus.issue_rs2, cnt_rs2, bus.wb_valid, bus.wb_rd);
    assign rd_full  = bus.issue_rd_wen && rd_at_max && !(ZERO_REG && bus.issue_rd == '0);
    assign raw      = bus.issue_valid &&
                      ((bus.issue_rs1_used && rs1_pend) || (bus.issue_rs2_used && rs2_pend));
    assign ready    = !raw && !bus.flush && !rd_full;
    assign fire     = bus.issue_valid && ready;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        localparam bit HARD = ZERO_REG && (g == 0);
        assign inc[g]     = !HARD && fire && bus.issue_rd_wen && bus.issue_rd == REG_ADDR_W'(g);
        assign dec_req[g] = !HARD && !bus.flush && bus.wb_valid && bus.wb_rd == REG_ADDR_W'(g);

        raw_pending_counter #(
            .CNT_W (CNT_W),
            .MAX   (MAX_INFLIGHT)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc[g]),
            .dec_req   (dec_req[g]),
            .clr       (bus.flush),
            .cnt       (cnt[g]),
            .at_max    (at_max[g]),
            .nonzero   (nonzero[g]),
            .underflow (underflow[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            if (bus.flush) begin
                underflow_q <= 1'b0;
            end else if (|underflow) begin
                underflow_q <= 1'b1;
            end
            if (bus.issue_valid && !ready && !bus.flush && stall_q != '1) begin
                stall_q <= stall_q + STALL_CNT_W'(1);
            end
        end
    end

    assign bus.issue_ready        = ready;
    assign bus.has_RAW_dependence = raw;
    assign bus.any_pending        = |nonzero;
    assign bus.wb_underflow       = underflow_q;
    assign bus.stall_cycles       = stall_q;

endmodule
